// File: rtl/jzjpcc_memory_arbiter.sv
// Single-port memory arbiter shared by the memory stage (read/write) and the
// instruction fetch (read-only). Data normally wins contention; fetch is
// guaranteed one contended cycle after STARVE_LIMIT consecutive denials.
// Read data returns one cycle after the enabled read and is steered back to
// whichever requester owned that read.
module jzjpcc_memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dataReq,
  input  logic        dataWriteEnable,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataWriteData,
  input  logic [3:0]  dataByteMask,
  output logic        dataStall,
  output logic        dataReadValid,
  output logic [31:0] dataReadData,
  input  logic        fetchReq,
  input  logic [31:0] fetchAddress,
  output logic        fetchStall,
  output logic        fetchReadValid,
  output logic [31:0] fetchReadData,
  output logic        memEnable,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memDataToWrite,
  output logic [3:0]  memByteMask,
  input  logic [31:0] memDataRead,
  output logic [15:0] dataGrantCount,
  output logic [15:0] fetchStallCount
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_count;
  logic       fetch_wins;
  logic       data_grant;
  logic       fetch_grant;
  logic       data_valid_q;
  logic       fetch_valid_q;

  // Grant decision: fetch takes the port when alone or when it has been
  // starved long enough; nothing is granted while reset is held.
  always_comb begin
    fetch_wins  = fetchReq & (~dataReq | (starve_count == LIMIT));
    data_grant  = ~reset & dataReq & ~fetch_wins;
    fetch_grant = ~reset & fetch_wins;
    dataStall   = ~reset & dataReq & ~data_grant;
    fetchStall  = ~reset & fetchReq & ~fetch_grant;
  end

  // Backend drive follows the winner; an idle port presents all zeros.
  always_comb begin
    memEnable      = 1'b0;
    memWriteEnable = 1'b0;
    memAddress     = 32'h0;
    memDataToWrite = 32'h0;
    memByteMask    = 4'h0;
    if (data_grant) begin
      memEnable      = 1'b1;
      memWriteEnable = dataWriteEnable;
      memAddress     = dataAddress;
      memDataToWrite = dataWriteData;
      memByteMask    = dataByteMask;
    end else if (fetch_grant) begin
      memEnable      = 1'b1;
      memAddress     = fetchAddress;
      memByteMask    = 4'hF;
    end
  end

  // Read returns are masked during reset so a read granted just before reset
  // never reports valid.
  always_comb begin
    dataReadValid  = data_valid_q & ~reset;
    fetchReadValid = fetch_valid_q & ~reset;
    dataReadData   = dataReadValid ? memDataRead : 32'h0;
    fetchReadData  = fetchReadValid ? memDataRead : 32'h0;
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_count <= 4'd0;
    end else if (!fetchReq || fetch_grant) begin
      starve_count <= 4'd0;
    end else if (starve_count != LIMIT) begin
      starve_count <= starve_count + 4'd1;
    end
  end

  // Remember which requester owns the read completing next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_valid_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      data_valid_q  <= data_grant & ~dataWriteEnable;
      fetch_valid_q <= fetch_grant;
    end
  end

  // Saturating performance counters for data grants and fetch stall cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataGrantCount  <= 16'h0;
      fetchStallCount <= 16'h0;
    end else begin
      if (data_grant && dataGrantCount != 16'hFFFF) begin
        dataGrantCount <= dataGrantCount + 16'd1;
      end
      if (fetchStall && fetchStallCount != 16'hFFFF) begin
        fetchStallCount <= fetchStallCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// Directed testbench for jzjpcc_memory_arbiter. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_jzjpcc_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        dataReq;
  logic        dataWriteEnable;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic [3:0]  dataByteMask;
  logic        dataStall;
  logic        dataReadValid;
  logic [31:0] dataReadData;
  logic        fetchReq;
  logic [31:0] fetchAddress;
  logic        fetchStall;
  logic        fetchReadValid;
  logic [31:0] fetchReadData;
  logic        memEnable;
  logic        memWriteEnable;
  logic [31:0] memAddress;
  logic [31:0] memDataToWrite;
  logic [3:0]  memByteMask;
  logic [31:0] memDataRead;
  logic [15:0] dataGrantCount;
  logic [15:0] fetchStallCount;

  int tests_run = 0;
  int tests_failed = 0;

  jzjpcc_memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .dataReq(dataReq), .dataWriteEnable(dataWriteEnable), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataByteMask(dataByteMask),
    .dataStall(dataStall), .dataReadValid(dataReadValid), .dataReadData(dataReadData),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress),
    .fetchStall(fetchStall), .fetchReadValid(fetchReadValid), .fetchReadData(fetchReadData),
    .memEnable(memEnable), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
    .memDataToWrite(memDataToWrite), .memByteMask(memByteMask), .memDataRead(memDataRead),
    .dataGrantCount(dataGrantCount), .fetchStallCount(fetchStallCount)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Return every request input to idle.
  task idle_inputs();
    dataReq = 1'b0; dataWriteEnable = 1'b0; dataAddress = 32'h0;
    dataWriteData = 32'h0; dataByteMask = 4'h0;
    fetchReq = 1'b0; fetchAddress = 32'h0; memDataRead = 32'h0;
  endtask

  // Two-cycle reset pulse used to isolate each scenario.
  task pulse_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task test_reset();
    @(negedge clock);
    reset = 1'b1; dataReq = 1'b1; fetchReq = 1'b1; dataWriteEnable = 1'b1;
    #1;
    tests_run++;
    if (memEnable !== 1'b0 || memWriteEnable !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem_off: memEnable=%b memWriteEnable=%b expected 0 0", memEnable, memWriteEnable);
    end
    tests_run++;
    if (dataStall !== 1'b0 || fetchStall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stalls: dataStall=%b fetchStall=%b expected 0 0", dataStall, fetchStall);
    end
    @(negedge clock);
    #1;
    tests_run++;
    if (dataReadValid !== 1'b0 || fetchReadValid !== 1'b0 || dataGrantCount !== 16'h0 || fetchStallCount !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: dv=%b fv=%b dgc=%h fsc=%h expected 0 0 0000 0000",
               dataReadValid, fetchReadValid, dataGrantCount, fetchStallCount);
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task test_data_read();
    pulse_reset();
    @(negedge clock);
    dataReq = 1'b1; dataWriteEnable = 1'b0; dataAddress = 32'h100;
    #1;
    tests_run++;
    if (memEnable !== 1'b1 || memAddress !== 32'h100 || dataStall !== 1'b0 || memWriteEnable !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL data_read_grant: en=%b addr=%h stall=%b we=%b expected 1 00000100 0 0",
               memEnable, memAddress, dataStall, memWriteEnable);
    end
    @(negedge clock);
    dataReq = 1'b0; memDataRead = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (dataReadValid !== 1'b1 || dataReadData !== 32'hDEADBEEF || fetchReadValid !== 1'b0 || fetchReadData !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL data_read_return: dv=%b dd=%h fv=%b fd=%h expected 1 deadbeef 0 00000000",
               dataReadValid, dataReadData, fetchReadValid, fetchReadData);
    end
    @(negedge clock);
    memDataRead = 32'h0;
    #1;
    tests_run++;
    if (dataReadValid !== 1'b0 || dataGrantCount !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL data_read_single: dv=%b dgc=%0d expected 0 1", dataReadValid, dataGrantCount);
    end
  endtask

  task test_data_write();
    pulse_reset();
    @(negedge clock);
    dataReq = 1'b1; dataWriteEnable = 1'b1; dataByteMask = 4'b0011;
    dataWriteData = 32'h1234; dataAddress = 32'h200;
    #1;
    tests_run++;
    if (memEnable !== 1'b1 || memWriteEnable !== 1'b1 || memByteMask !== 4'b0011 ||
        memDataToWrite !== 32'h1234 || memAddress !== 32'h200) begin
      tests_failed++;
      $display("[TB] FAIL data_write_drive: en=%b we=%b mask=%b wd=%h addr=%h expected 1 1 0011 00001234 00000200",
               memEnable, memWriteEnable, memByteMask, memDataToWrite, memAddress);
    end
    @(negedge clock);
    idle_inputs();
    memDataRead = 32'hCAFEF00D;
    #1;
    tests_run++;
    if (dataReadValid !== 1'b0 || dataReadData !== 32'h0 || dataGrantCount !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL data_write_novalid: dv=%b dd=%h dgc=%0d expected 0 00000000 1",
               dataReadValid, dataReadData, dataGrantCount);
    end
  endtask

  task test_starvation();
    logic fetch_turn;
    logic prev_fetch;
    pulse_reset();
    @(negedge clock);
    dataReq = 1'b1; dataWriteEnable = 1'b0; dataAddress = 32'h300;
    fetchReq = 1'b1; fetchAddress = 32'h400;
    prev_fetch = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      fetch_turn = (cyc == 4) || (cyc == 9);
      tests_run++;
      if (memAddress !== (fetch_turn ? 32'h400 : 32'h300) || dataStall !== fetch_turn || fetchStall !== !fetch_turn) begin
        tests_failed++;
        $display("[TB] FAIL starve_cycle%0d: addr=%h dStall=%b fStall=%b expected %h %b %b",
                 cyc, memAddress, dataStall, fetchStall, fetch_turn ? 32'h400 : 32'h300, fetch_turn, !fetch_turn);
      end
      if (cyc > 0) begin
        tests_run++;
        if (dataReadValid !== !prev_fetch || fetchReadValid !== prev_fetch) begin
          tests_failed++;
          $display("[TB] FAIL starve_valid%0d: dv=%b fv=%b expected %b %b",
                   cyc, dataReadValid, fetchReadValid, !prev_fetch, prev_fetch);
        end
      end
      prev_fetch = fetch_turn;
      @(negedge clock);
    end
    idle_inputs();
    #1;
    tests_run++;
    if (fetchStallCount !== 16'd8 || dataGrantCount !== 16'd8) begin
      tests_failed++;
      $display("[TB] FAIL starve_counts: fsc=%0d dgc=%0d expected 8 8", fetchStallCount, dataGrantCount);
    end
  endtask

  task test_fetch_stream();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      fetchReq = 1'b1; fetchAddress = 32'(4 * i); memDataRead = 32'h1000 + 32'(i);
      #1;
      tests_run++;
      if (memEnable !== 1'b1 || memWriteEnable !== 1'b0 || memAddress !== 32'(4 * i) ||
          memByteMask !== 4'hF || memDataToWrite !== 32'h0 || fetchStall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL fetch_drive%0d: en=%b we=%b addr=%h mask=%h wd=%h stall=%b expected 1 0 %h f 00000000 0",
                 i, memEnable, memWriteEnable, memAddress, memByteMask, memDataToWrite, fetchStall, 32'(4 * i));
      end
      tests_run++;
      if (fetchReadValid !== (i > 0) || fetchReadData !== ((i > 0) ? 32'h1000 + 32'(i) : 32'h0)) begin
        tests_failed++;
        $display("[TB] FAIL fetch_valid%0d: fv=%b fd=%h expected %b %h",
                 i, fetchReadValid, fetchReadData, (i > 0), (i > 0) ? 32'h1000 + 32'(i) : 32'h0);
      end
    end
    @(negedge clock);
    fetchReq = 1'b0; memDataRead = 32'h1003;
    #1;
    tests_run++;
    if (fetchReadValid !== 1'b1 || fetchReadData !== 32'h1003 || dataReadValid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_last: fv=%b fd=%h dv=%b expected 1 00001003 0", fetchReadValid, fetchReadData, dataReadValid);
    end
    @(negedge clock);
    #1;
    tests_run++;
    if (fetchReadValid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_end: fv=%b expected 0", fetchReadValid);
    end
  endtask

  task test_reset_mid();
    pulse_reset();
    @(negedge clock);
    dataReq = 1'b1; dataWriteEnable = 1'b0; dataAddress = 32'h500; fetchReq = 1'b1;
    #1;
    tests_run++;
    if (memEnable !== 1'b1 || memAddress !== 32'h500 || fetchStall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_grant: en=%b addr=%h fStall=%b expected 1 00000500 1", memEnable, memAddress, fetchStall);
    end
    @(negedge clock);
    idle_inputs();
    reset = 1'b1; memDataRead = 32'hBAD0BAD0;
    #1;
    tests_run++;
    if (dataReadValid !== 1'b0 || dataReadData !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_n1: dv=%b dd=%h expected 0 00000000", dataReadValid, dataReadData);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests_run++;
    if (dataReadValid !== 1'b0 || dataGrantCount !== 16'h0 || fetchStallCount !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_n2: dv=%b dgc=%h fsc=%h expected 0 0000 0000", dataReadValid, dataGrantCount, fetchStallCount);
    end
  endtask

  task test_saturation();
    pulse_reset();
    @(negedge clock);
    dataReq = 1'b1; dataWriteEnable = 1'b1; dataByteMask = 4'hF;
    repeat (65534) @(negedge clock);
    #1;
    tests_run++;
    if (dataGrantCount !== 16'hFFFE) begin
      tests_failed++;
      $display("[TB] FAIL sat_before: dgc=%h expected fffe", dataGrantCount);
    end
    repeat (6) @(negedge clock);
    dataReq = 1'b0;
    #1;
    tests_run++;
    if (dataGrantCount !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: dgc=%h expected ffff", dataGrantCount);
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_data_read();
    test_data_write();
    test_starvation();
    test_fetch_stream();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jzjpcc_memory_arbiter.md
JZJPCC_MEMORY_ARBITER -- requirements
Module: jzjpcc_memory_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied fetch-request cycles after which fetch wins one contended cycle (legal 1..15).
REQ-002 SHALL have ports `clock`, in, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port `reset`, in, 1, synchronous, active-high.
REQ-004 SHALL have ports `dataReq` in 1, `dataWriteEnable` in 1, `dataAddress` in 32, `dataWriteData` in 32, `dataByteMask` in 4; these form the memory-stage request.
REQ-005 SHALL have ports `dataStall` out 1, `dataReadValid` out 1, `dataReadData` out 32.
REQ-006 SHALL have ports `fetchReq` in 1 and `fetchAddress` in 32; these form the read-only fetch request.
REQ-007 SHALL have ports `fetchStall` out 1, `fetchReadValid` out 1, `fetchReadData` out 32.
REQ-008 SHALL have ports `memEnable` out 1, `memWriteEnable` out 1, `memAddress` out 32, `memDataToWrite` out 32, `memByteMask` out 4, and `memDataRead` in 32; these form the single-port backend, and read data is valid exactly 1 cycle after the enabled read.
REQ-009 SHALL have ports `dataGrantCount` out 16 and `fetchStallCount` out 16, which are saturating performance counters.

Function
REQ-010 SHALL decide the grant combinationally each cycle as follows.
- Only one requester active: that requester wins.
- Both active: data wins unless the starvation counter equals STARVE_LIMIT, in which case fetch wins.
REQ-011 SHALL keep a starvation counter.
- Increments on each cycle where fetchReq=1 and fetch is not granted, saturating at STARVE_LIMIT.
- Clears on any fetch grant and on any cycle with fetchReq=0.
REQ-012 SHALL drive the backend according to the winner.
- Data granted: memEnable=1; memWriteEnable=dataWriteEnable; memAddress=dataAddress; memDataToWrite=dataWriteData; memByteMask=dataByteMask.
- Fetch granted: memEnable=1; memWriteEnable=0; memAddress=fetchAddress; memByteMask=4'hF; memDataToWrite=0.
- No grant: memEnable=0, memWriteEnable=0, all other backend outputs 0.
REQ-013 SHALL drive `dataStall` = dataReq & ~dataGranted and `fetchStall` = fetchReq & ~fetchGranted, both combinational in the same cycle.
REQ-014 SHALL assert `dataReadValid` for exactly 1 cycle, in the cycle after a data grant with dataWriteEnable=0; a granted write produces no valid.
REQ-015 SHALL assert `fetchReadValid` for exactly 1 cycle, in the cycle after a fetch grant.
REQ-016 SHALL drive `dataReadData` and `fetchReadData` as `memDataRead` whenever the corresponding valid is 1, and 0 otherwise.
REQ-017 SHALL never assert both read valids in the same cycle, and SHALL never grant both requesters in one cycle.
REQ-018 SHALL update the performance counters as follows, both saturating at 16'hFFFF with no wrap.
- `dataGrantCount` increments on every data grant.
- `fetchStallCount` increments on every cycle where fetchStall=1.
REQ-019 SHALL pass request inputs through to the backend without holding them; requesters hold their request stable while stalled.

Reset
REQ-020 SHALL, while reset=1, force memEnable=0, memWriteEnable=0, dataStall=0 and fetchStall=0 regardless of requests.
REQ-021 SHALL, on a clock edge with reset=1, clear the starvation counter, both read-valid registers, dataGrantCount and fetchStallCount to 0.
REQ-022 SHALL cancel any read granted in the cycle before reset: its valid is not asserted after reset.
REQ-023 SHALL resume arbitration in the first cycle with reset=0, with the starvation counter at 0.

Verification
REQ-024 Bench SHALL cover data read alone: dataReq=1, dataWriteEnable=0, dataAddress=0x100, memDataRead=0xDEADBEEF next cycle -> memEnable=1, memAddress=0x100, dataStall=0; next cycle dataReadValid=1, dataReadData=0xDEADBEEF, fetchReadValid=0.
REQ-025 Bench SHALL cover data write: dataReq=1, dataWriteEnable=1, dataByteMask=4'b0011, dataWriteData=0x1234 -> memWriteEnable=1, memByteMask=4'b0011; next cycle dataReadValid=0; dataGrantCount=1.
REQ-026 Bench SHALL cover starvation with STARVE_LIMIT=4 and both requesting continuously -> data granted cycles 0-3 (fetchStall=1), fetch granted cycle 4 (dataStall=1), data cycles 5-8, fetch cycle 9; fetchStallCount=8 after cycle 9.
REQ-027 Bench SHALL cover a fetch-only stream: fetchReq=1 for 3 cycles, addresses 0x0/0x4/0x8 -> memWriteEnable=0, memByteMask=4'hF each cycle; fetchReadValid=1 in cycles 1-3.
REQ-028 Bench SHALL cover reset mid-operation: a data read is granted in cycle N and reset=1 in cycle N+1 -> dataReadValid=0 in cycles N+1 and N+2; all counters read 0 after release.
REQ-029 Bench SHALL cover counter saturation: force 65540 data grants -> dataGrantCount=16'hFFFF, with no wrap to 0.
